adc_stream_packetizer: RTL and testbench

ADC_STREAM_PACKETIZER -- requirements
Module: adc_stream_packetizer

---
 rtl/adc_input_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/adc_stream_packetizer.sv | 155 +++++++++++++++
 tb/tb_adc_stream_packetizer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_input_pkg.sv
// Shared types and defaults for the ADC stream packetizer and its buffer.
package adc_input_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_FIFO_DEPTH = 1024;
    localparam int DEF_CNT_W      = 32;

    // Address width of a power-of-two buffer depth.
    function automatic int clog2_depth(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is held in an
// output register loaded from a registered RAM read, with a write bypass.
module sync_fifo
    import adc_input_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW   = clog2_depth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_ok, rd_ok;

    always_comb begin
        rd_ok    = rd_en && (cnt_q != '0);
        // A full buffer still takes a write when a word leaves in the same cycle.
        wr_ok    = wr_en && (!cnt_q[AW] || rd_ok);
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        cnt_d    = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        // Bypass covers the word being written into the next head slot.
        dout_d   = (wr_ok && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    assign rd_data = dout_q;
    assign full    = cnt_q[AW];
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;

endmodule

// File: rtl/adc_stream_packetizer.sv
// Collects (optionally decimated or test-pattern) ADC samples into dsize-long
// AXI-Stream packets through an internal FWFT buffer.
module adc_stream_packetizer
    import adc_input_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_areset,
    input  logic                  adc_valid,
    input  logic [DATA_W-1:0]     adc_data,
    input  logic [CNT_W-1:0]      dsize,
    input  logic [7:0]            decim,
    input  logic                  test,
    input  logic                  cont,
    input  logic                  start,
    output logic                  m00_axis_tvalid,
    output logic [DATA_W-1:0]     m00_axis_tdata,
    output logic [DATA_W/8-1:0]   m00_axis_tkeep,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    output logic                  sr_pc,
    output logic                  sr_ovf
);

    localparam int AW = clog2_depth(FIFO_DEPTH);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    dsize_q, dsize_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [7:0]          decim_q, decim_d;
    logic [7:0]          dec_cnt_q, dec_cnt_d;
    logic                test_q, test_d;
    logic                ovf_q, ovf_d;
    logic                pc_q, pc_d;

    logic                fifo_rst, fifo_full, fifo_empty;
    logic [AW:0]         fifo_count;
    logic [DATA_W-1:0]   fifo_rd_data, wr_data;
    logic                pop, accept, wr_req, push, last_word, arm;

    // Stream handshake: a word transfers on every rising edge where tvalid and
    // tready are both high; tvalid never depends on tready, and once raised the
    // word (tdata/tlast) holds until that transfer happens.
    always_comb begin
        pop       = m00_axis_tvalid && m00_axis_tready;
        last_word = (rd_cnt_q == dsize_q - CNT_W'(1));
        accept    = test_q || (adc_valid && (dec_cnt_q == decim_q));
        wr_req    = (state_q == S_RUN) && accept;
        push      = wr_req && (!fifo_full || pop);
        wr_data   = test_q ? DATA_W'(wr_cnt_q) : adc_data;
        fifo_rst  = m00_axis_areset || (state_q == S_IDLE);
    end

    always_comb begin
        state_d   = state_q;
        dsize_d   = dsize_q;
        decim_d   = decim_q;
        test_d    = test_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        dec_cnt_d = dec_cnt_q;
        ovf_d     = ovf_q;
        arm       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (dsize != '0)) begin
                    arm   = 1'b1;
                    ovf_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!test_q && adc_valid)
                    dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
                if (wr_req && !push) ovf_d = 1'b1;
                if (push) begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q == dsize_q - CNT_W'(1)) state_d = S_DRAIN;
                end
            end
            default: ;
        endcase

        if (state_q != S_IDLE && pop) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (m00_axis_tlast) begin
                if (cont && (dsize != '0)) arm = 1'b1;
                else                       state_d = S_IDLE;
            end
        end

        // Starting a packet, fresh or re-armed, re-latches its setup.
        if (arm) begin
            dsize_d   = dsize;
            decim_d   = decim;
            test_d    = test;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            dec_cnt_d = '0;
            state_d   = S_RUN;
        end
        pc_d = (state_d == S_IDLE);
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_q   <= S_IDLE;
            dsize_q   <= '0;
            decim_q   <= '0;
            test_q    <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            dec_cnt_q <= '0;
            ovf_q     <= 1'b0;
            pc_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            dsize_q   <= dsize_d;
            decim_q   <= decim_d;
            test_q    <= test_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            dec_cnt_q <= dec_cnt_d;
            ovf_q     <= ovf_d;
            pc_q      <= pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (m00_axis_aclk),
        .rst     (fifo_rst),
        .wr_en   (push),
        .wr_data (wr_data),
        .rd_en   (m00_axis_tready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m00_axis_tvalid = (fifo_count != '0);
    assign m00_axis_tdata  = fifo_empty ? '0 : fifo_rd_data;
    assign m00_axis_tkeep  = '1;
    assign m00_axis_tlast  = m00_axis_tvalid && last_word;
    assign sr_pc           = pc_q;
    assign sr_ovf          = ovf_q;

endmodule

// File: tb/tb_adc_stream_packetizer.sv
// Bench for adc_stream_packetizer: directed scenarios plus randomized packets
// checked against a sample-selection model of decimation and packet length.
module tb_adc_stream_packetizer;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 32;

    logic                clk = 1'b0;
    logic                areset;
    logic                adc_valid;
    logic [DATA_W-1:0]   adc_data;
    logic [CNT_W-1:0]    dsize;
    logic [7:0]          decim;
    logic                test, cont, start;
    logic                tvalid, tlast, tready;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                sr_pc, sr_ovf;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              exp_last_q[$];
    logic              in_v_q[$];
    logic [DATA_W-1:0] in_d_q[$];

    adc_stream_packetizer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (areset),
        .adc_valid       (adc_valid),
        .adc_data        (adc_data),
        .dsize           (dsize),
        .decim           (decim),
        .test            (test),
        .cont            (cont),
        .start           (start),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tdata  (tdata),
        .m00_axis_tkeep  (tkeep),
        .m00_axis_tlast  (tlast),
        .m00_axis_tready (tready),
        .sr_pc           (sr_pc),
        .sr_ovf          (sr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Model: of the valid samples after start, every (dec+1)-th is kept,
    // until dsz samples are kept; the dsz-th carries tlast.
    task automatic gen_packet(input int dsz, input int dec, input int vpct,
                              input bit ramp, input int base);
        int k = 0;
        int kept = 0;
        int i = 0;
        logic v;
        logic [DATA_W-1:0] d;
        in_v_q.delete(); in_d_q.delete(); exp_q.delete(); exp_last_q.delete();
        while (kept < dsz) begin
            v = ramp ? 1'b1 : ($urandom_range(0, 99) < vpct);
            d = ramp ? DATA_W'(base + i) : DATA_W'($urandom);
            in_v_q.push_back(v);
            in_d_q.push_back(d);
            if (v) begin
                if (k % (dec + 1) == dec) begin
                    exp_q.push_back(d);
                    exp_last_q.push_back(kept == dsz - 1);
                    kept++;
                end
                k++;
            end
            i++;
        end
    endtask

    // Test pattern: each packet counts 0..dsz-1.
    task automatic gen_test(input int dsz, input int reps);
        in_v_q.delete(); in_d_q.delete(); exp_q.delete(); exp_last_q.delete();
        for (int r = 0; r < reps; r++)
            for (int j = 0; j < dsz; j++) begin
                exp_q.push_back(DATA_W'(j));
                exp_last_q.push_back(j == dsz - 1);
            end
    endtask

    task automatic do_start(input int dsz, input int dec, input bit tst, input bit cnt);
        dsize = CNT_W'(dsz);
        decim = 8'(dec);
        test  = tst;
        cont  = cnt;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random, 3 low for low_cycles then high.
    task automatic drain_stream(input int n_beats, input int rdy_mode, input int low_cycles,
                                input int budget, input bit chk_busy);
        int beats = 0;
        int cyc = 0;
        bit prev_stall = 1'b0;
        while (beats < n_beats && cyc < budget) begin
            if (in_v_q.size() > 0) begin
                adc_valid = in_v_q.pop_front();
                adc_data  = in_d_q.pop_front();
            end else begin
                adc_valid = 1'b0;
                adc_data  = '0;
            end
            case (rdy_mode)
                0: tready = 1'b1;
                1: tready = (cyc % 2 == 0);
                2: tready = ($urandom_range(0, 3) != 0);
                default: tready = (cyc >= low_cycles);
            endcase
            if (prev_stall) check("stall_tvalid", 64'(tvalid), 64'd1);
            if (exp_q.size() == 0) begin
                check("extra_tvalid", 64'(tvalid), 64'd0);
            end else if (tvalid) begin
                check("tdata", 64'(tdata), 64'(exp_q[0]));
                check("tlast", 64'(tlast), 64'(exp_last_q[0]));
                check("tkeep", 64'(tkeep), 64'({(DATA_W/8){1'b1}}));
                if (tready) begin
                    void'(exp_q.pop_front());
                    void'(exp_last_q.pop_front());
                    beats++;
                end
            end
            if (chk_busy) check("sr_pc_busy", 64'(sr_pc), 64'd0);
            prev_stall = tvalid && !tready;
            step();
            cyc++;
        end
        adc_valid = 1'b0;
        adc_data  = '0;
        check("beat_count", 64'(beats), 64'(n_beats));
    endtask

    task automatic idle_quiet(input int n);
        tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("idle_tvalid", 64'(tvalid), 64'd0);
            check("idle_sr_pc", 64'(sr_pc), 64'd1);
            step();
        end
    endtask

    initial begin
        int dsz;
        int dec;
        areset = 1'b1; adc_valid = 1'b0; adc_data = '0; dsize = '0; decim = '0;
        test = 1'b0; cont = 1'b0; start = 1'b0; tready = 1'b0;

        // Reset values, while reset is held
        repeat (3) step();
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_sr_pc", 64'(sr_pc), 64'd1);
        check("rst_sr_ovf", 64'(sr_ovf), 64'd0);
        areset = 1'b0;
        step();
        check("post_rst_sr_pc", 64'(sr_pc), 64'd1);

        // start with dsize==0 is ignored
        adc_valid = 1'b1;
        adc_data  = 16'h1234;
        do_start(0, 0, 0, 0);
        idle_quiet(4);
        adc_valid = 1'b0;

        // Plain packet, data 100..107
        gen_packet(8, 0, 100, 1'b1, 100);
        do_start(8, 0, 0, 0);
        drain_stream(8, 0, 0, 100, 1'b0);
        check("pc_after_plain", 64'(sr_pc), 64'd1);
        check("ovf_after_plain", 64'(sr_ovf), 64'd0);

        // Test pattern with toggling ready; a start inside the packet is ignored
        gen_test(5, 1);
        tready = 1'b0;
        do_start(5, 0, 1, 0);
        start = 1'b1;
        dsize = CNT_W'(2);
        step();
        start = 1'b0;
        dsize = CNT_W'(5);
        drain_stream(5, 1, 0, 100, 1'b1);
        check("pc_after_test", 64'(sr_pc), 64'd1);
        idle_quiet(2);
        test = 1'b0;

        // Decimation by 4
        gen_packet(4, 3, 100, 1'b1, 0);
        do_start(4, 3, 0, 0);
        drain_stream(4, 0, 0, 100, 1'b0);
        check("pc_after_decim", 64'(sr_pc), 64'd1);

        // Overflow: 40 samples into a 16-deep buffer with ready held low
        gen_test(40, 1);
        do_start(40, 0, 1, 0);
        drain_stream(40, 3, 30, 300, 1'b0);
        check("ovf_set", 64'(sr_ovf), 64'd1);
        check("pc_after_ovf", 64'(sr_pc), 64'd1);
        gen_test(2, 1);
        do_start(2, 0, 1, 0);
        check("ovf_cleared_by_start", 64'(sr_ovf), 64'd0);
        drain_stream(2, 0, 0, 100, 1'b0);
        test = 1'b0;

        // Continuous mode: three back-to-back packets of 3
        gen_test(3, 3);
        do_start(3, 0, 1, 1);
        drain_stream(6, 0, 0, 100, 1'b1);
        cont = 1'b0;
        drain_stream(3, 0, 0, 100, 1'b1);
        check("pc_after_cont", 64'(sr_pc), 64'd1);
        idle_quiet(3);
        test = 1'b0;

        // Reset during beat 2 of a 10-sample packet
        gen_packet(10, 0, 100, 1'b1, 50);
        do_start(10, 0, 0, 0);
        drain_stream(1, 0, 0, 50, 1'b0);
        areset = 1'b1;
        tready = 1'b1;
        step();
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_tlast", 64'(tlast), 64'd0);
        check("midrst_tdata", 64'(tdata), 64'd0);
        check("midrst_sr_pc", 64'(sr_pc), 64'd1);
        areset = 1'b0;
        step();
        gen_packet(2, 0, 100, 1'b1, 200);
        do_start(2, 0, 0, 0);
        drain_stream(2, 0, 0, 50, 1'b0);
        check("pc_after_midrst", 64'(sr_pc), 64'd1);
        idle_quiet(4);

        // Randomized packets: random length, decimation, valid pattern and ready
        for (int r = 0; r < 6; r++) begin
            dsz = $urandom_range(1, 16);
            dec = $urandom_range(0, 3);
            gen_packet(dsz, dec, 60, 1'b0, 0);
            do_start(dsz, dec, 0, 0);
            drain_stream(dsz, 2, 0, 600, 1'b0);
            check("pc_after_rand", 64'(sr_pc), 64'd1);
            check("ovf_after_rand", 64'(sr_ovf), 64'd0);
            idle_quiet(2);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
